iterative_multdiv: RTL and testbench

ITERATIVE_MULTDIV -- requirements
Module: iterative_multdiv

---
 rtl/multdiv_pkg.sv | 20 ++
 rtl/addsub33.sv | 17 +
 rtl/iterative_multdiv.sv | 140 ++++++++++++++
 tb/tb_iterative_multdiv.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/multdiv_pkg.sv
// multdiv_pkg: shared types and constants for the iterative multiply/divide unit.
//   state_t   - control FSM states
//   DEF_WIDTH - default operand/result width
//   DEF_ITER  - default iterations per operation
//   INT_MIN   - most negative 32-bit two's complement value
package multdiv_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_ITER  = 32;

    localparam logic [31:0] INT_MIN = 32'h8000_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MULT = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/addsub33.sv
// addsub33: (WIDTH+1)-bit adder/subtractor shared by the multiply accumulate
// step and the non-restoring divide step.
//   a, b - operands
//   sub  - 1: sum = a - b, 0: sum = a + b
//   sum  - result, carry/borrow out discarded
module addsub33 #(
    parameter int N = 33
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         sub,
    output logic [N-1:0] sum
);

    assign sum = sub ? (a - b) : (a + b);

endmodule

// File: rtl/iterative_multdiv.sv
// iterative_multdiv: signed multiply / divide, one bit per cycle, fixed latency.
//   clock, reset          - rising-edge clock, async active-high reset
//   data_operandA/B       - multiplicand/multiplier or dividend/divisor
//   ctrl_MULT, ctrl_DIV   - one-cycle start pulses (MULT wins if both high)
//   data_result           - product low word or quotient, held until next DONE
//   data_exception        - multiply overflow, divide-by-zero or INT_MIN / -1
//   data_resultRDY        - high for the single DONE cycle
// Both operations run on operand magnitudes; the sign is re-applied when the
// result is registered, so the shared adder only ever sees unsigned data.
module iterative_multdiv
    import multdiv_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int ITER  = DEF_ITER
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY
);

    localparam logic [WIDTH-1:0] MIN_VAL = INT_MIN[31 -: WIDTH];

    state_t           state, next_state;
    logic [5:0]       cnt;
    logic [WIDTH:0]   hi;      // mult: upper product half; div: signed partial remainder
    logic [WIDTH-1:0] lo;      // mult: multiplier / lower product; div: dividend / quotient
    logic [WIDTH-1:0] mag_b;   // multiplicand or divisor magnitude
    logic             neg;
    logic             div_zero, div_ovf;

    logic             start, busy, last_iter;
    logic [WIDTH-1:0] mag_a_in, mag_b_in;
    logic [WIDTH:0]   add_a, add_b, sum;
    logic             add_sub;
    logic [2*WIDTH-1:0] prod, sprod;
    logic [WIDTH-1:0] quo;

    assign start     = ctrl_MULT | ctrl_DIV;
    assign busy      = (state == MULT) || (state == DIV);
    assign last_iter = (cnt == 6'(ITER));
    assign mag_a_in  = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
    assign mag_b_in  = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;

    assign data_resultRDY = (state == DONE);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        if (ctrl_MULT)     next_state = MULT;
        else if (ctrl_DIV) next_state = DIV;
        else begin
            case (state)
                MULT, DIV: if (last_iter) next_state = DONE;
                DONE:      next_state = IDLE;
                default:   next_state = state;
            endcase
        end
    end

    // Multiply: add multiplicand when the multiplier LSB is set, then the
    // whole {hi,lo} pair shifts right. Divide: shift {rem,quo} left, add or
    // subtract the divisor depending on the remainder sign (non-restoring).
    always_comb begin
        add_a   = {1'b0, hi[WIDTH-1:0]};
        add_b   = lo[0] ? {1'b0, mag_b} : '0;
        add_sub = 1'b0;
        if (state == DIV) begin
            add_a   = {hi[WIDTH-1:0], lo[WIDTH-1]};
            add_b   = {1'b0, mag_b};
            add_sub = ~hi[WIDTH];
        end
    end

    addsub33 #(.N(WIDTH+1)) u_addsub (
        .a   (add_a),
        .b   (add_b),
        .sub (add_sub),
        .sum (sum)
    );

    assign prod  = {hi[WIDTH-1:0], lo};
    assign sprod = neg ? -prod : prod;
    assign quo   = neg ? -lo : lo;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt            <= '0;
            hi             <= '0;
            lo             <= '0;
            mag_b          <= '0;
            neg            <= 1'b0;
            div_zero       <= 1'b0;
            div_ovf        <= 1'b0;
            data_result    <= '0;
            data_exception <= 1'b0;
        end else if (start) begin
            cnt      <= '0;
            hi       <= '0;
            lo       <= mag_a_in;
            mag_b    <= mag_b_in;
            neg      <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
            div_zero <= ~ctrl_MULT & (data_operandB == '0);
            div_ovf  <= ~ctrl_MULT & (data_operandA == MIN_VAL) & (&data_operandB);
        end else if (busy) begin
            cnt <= cnt + 6'd1;
            if (!last_iter) begin
                if (state == DIV) begin
                    hi <= sum;
                    lo <= {lo[WIDTH-2:0], ~sum[WIDTH]};
                end else begin
                    hi <= {1'b0, sum[WIDTH:1]};
                    lo <= {sum[0], lo[WIDTH-1:1]};
                end
            end else if (state == MULT) begin
                data_result    <= sprod[WIDTH-1:0];
                data_exception <= (sprod[2*WIDTH-1:WIDTH] != {WIDTH{sprod[WIDTH-1]}});
            end else if (div_zero) begin
                data_result    <= '0;
                data_exception <= 1'b1;
            end else if (div_ovf) begin
                data_result    <= MIN_VAL;
                data_exception <= 1'b1;
            end else begin
                data_result    <= quo;
                data_exception <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_iterative_multdiv.sv
// tb_iterative_multdiv: scoreboard bench for iterative_multdiv. Each start
// pushes the expected result, exception and completion edge; every
// data_resultRDY pops and compares. Aborts and resets drop pending entries,
// so any result from a killed operation shows up as a spurious pulse.
module tb_iterative_multdiv;
    import multdiv_pkg::*;

    localparam int ITER = 32;

    typedef struct {
        logic [31:0] res;
        logic        exc;
        int          due;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] data_operandA = '0;
    logic [31:0] data_operandB = '0;
    logic        ctrl_MULT = 1'b0;
    logic        ctrl_DIV  = 1'b0;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;

    exp_t        sb[$];
    int          edge_cnt = 0;
    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] last_res = '0;
    logic        last_exc = 1'b0;

    iterative_multdiv dut (
        .clock          (clock),
        .reset          (reset),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .ctrl_MULT      (ctrl_MULT),
        .ctrl_DIV       (ctrl_DIV),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY)
    );

    always #5 clock = ~clock;

    always @(posedge clock) edge_cnt <= edge_cnt + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (edge %0d)", tag, got, exp, edge_cnt);
        end
    endtask

    function automatic exp_t model(input logic m, input logic [31:0] a, input logic [31:0] b);
        exp_t   e;
        longint p;
        int     q;
        e.due = 0;
        if (m) begin
            p     = longint'($signed(a)) * longint'($signed(b));
            e.res = p[31:0];
            e.exc = (p != longint'($signed(p[31:0])));
        end else if (b == 32'd0) begin
            e.res = '0;
            e.exc = 1'b1;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            e.res = 32'h8000_0000;
            e.exc = 1'b1;
        end else begin
            q     = $signed(a) / $signed(b);
            e.res = q;
            e.exc = 1'b0;
        end
        return e;
    endfunction

    // Result monitor, sampled on the falling edge.
    always @(negedge clock) begin
        if (data_resultRDY === 1'b1) begin
            if (sb.size() == 0) begin
                check("spurious_rdy", 64'(data_resultRDY), 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("result",    64'(data_result),    64'(e.res));
                check("exception", 64'(data_exception), 64'(e.exc));
                check("rdy_cycle", 64'(edge_cnt),       64'(e.due));
                last_res = e.res;
                last_exc = e.exc;
            end
        end
    end

    // Drive a start pulse for one cycle; operands are scrambled afterwards so
    // any failure to latch them shows up in the result.
    task automatic start(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        @(negedge clock);
        ctrl_MULT     = m;
        ctrl_DIV      = d;
        data_operandA = a;
        data_operandB = b;
        e     = model(m, a, b);
        e.due = edge_cnt + 1 + ITER + 1;
        sb.delete();
        sb.push_back(e);
        @(negedge clock);
        ctrl_MULT     = 1'b0;
        ctrl_DIV      = 1'b0;
        data_operandA = $urandom;
        data_operandB = $urandom;
    endtask

    task automatic wait_done();
        int n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clock);
            n++;
        end
        check("timeout", 64'(sb.size()), 64'd0);
        repeat (3) @(negedge clock);
        check("hold_res", 64'(data_result),    64'(last_res));
        check("hold_exc", 64'(data_exception), 64'(last_exc));
    endtask

    initial begin
        logic        m;
        logic [31:0] a, b;

        repeat (3) @(negedge clock);
        check("rst_res", 64'(data_result),    64'd0);
        check("rst_exc", 64'(data_exception), 64'd0);
        check("rst_rdy", 64'(data_resultRDY), 64'd0);
        reset = 1'b0;
        repeat (2) @(negedge clock);

        start(1'b1, 1'b0, 32'd7, 32'hFFFF_FFFD);          wait_done();
        start(1'b1, 1'b0, 32'h0001_0000, 32'h0001_0000);  wait_done();
        start(1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2);          wait_done();
        start(1'b0, 1'b1, 32'd5, 32'd0);                  wait_done();
        start(1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);  wait_done();
        start(1'b1, 1'b0, 32'h8000_0000, 32'd1);          wait_done();
        start(1'b1, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF);  wait_done();
        start(1'b0, 1'b1, 32'h8000_0000, 32'd1);          wait_done();
        start(1'b0, 1'b1, 32'd100, 32'hFFFF_FFF9);        wait_done();
        // both strobes together: multiply wins
        start(1'b1, 1'b1, 32'd6, 32'd7);                  wait_done();

        // abort: divide issued 10 edges into a multiply
        start(1'b1, 1'b0, 32'd3, 32'd4);
        repeat (8) @(negedge clock);
        start(1'b0, 1'b1, 32'd100, 32'd7);
        wait_done();

        // reset in the middle of a multiply
        start(1'b1, 1'b0, 32'd3, 32'd4);
        repeat (13) @(negedge clock);
        reset = 1'b1;
        sb.delete();
        #1;
        check("midrst_res", 64'(data_result),    64'd0);
        check("midrst_exc", 64'(data_exception), 64'd0);
        check("midrst_rdy", 64'(data_resultRDY), 64'd0);
        @(negedge clock);
        reset = 1'b0;
        repeat (40) @(negedge clock);
        start(1'b1, 1'b0, 32'd3, 32'd4);                  wait_done();

        for (int i = 0; i < 16; i++) begin
            m = 1'($urandom_range(0, 1));
            a = $urandom;
            if (i % 5 == 0)      b = '0;
            else if (i % 3 == 0) b = 32'($urandom_range(1, 15));
            else                 b = $urandom;
            if (i % 4 == 2)      a = a >>> 20;
            start(m, ~m, a, b);
            wait_done();
        end

        repeat (5) @(negedge clock);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
